// File: rtl/mmio_hub_pkg.sv
// Shared constants for the MMIO hub: default register addresses, STATUS bit
// positions and the register-select encoding used by the decoder.
package mmio_hub_pkg;

  localparam logic [31:0] UTX_ADDR_DEF    = 32'h0000_0000;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0004;
  localparam logic [31:0] FINISH_ADDR_DEF = 32'h0000_0008;
  localparam logic [31:0] CYCLE_ADDR_DEF  = 32'h0000_000C;
  localparam logic [31:0] LED_ADDR_DEF    = 32'h0000_0010;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_FIN     = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_UTX,
    SEL_STATUS,
    SEL_FINISH,
    SEL_CYCLE,
    SEL_LED
  } reg_sel_e;

  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       fin,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [31:0] s;
    s                         = '0;
    s[STAT_EMPTY]             = empty;
    s[STAT_FULL]              = full;
    s[STAT_FIN]               = fin;
    s[STAT_OVF]               = ovf;
    s[STAT_CNT_LSB +: 8]      = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_hub_sync_fifo.sv
// Synchronous FIFO with combinational head read; push is ignored when full,
// pop is ignored when empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full check uses the pre-pop count, so a push on a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped peripheral hub: address decode, UART TX FIFO, status/finish,
// free-running cycle counter, LED register and a one-cycle registered read mux.
module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int                  DATA_LEN    = 32,
  parameter int                  ADDR_LEN    = 32,
  parameter int                  FIFO_DEPTH  = 16,
  parameter logic [ADDR_LEN-1:0] UTX_ADDR    = ADDR_LEN'(UTX_ADDR_DEF),
  parameter logic [ADDR_LEN-1:0] STATUS_ADDR = ADDR_LEN'(STATUS_ADDR_DEF),
  parameter logic [ADDR_LEN-1:0] FINISH_ADDR = ADDR_LEN'(FINISH_ADDR_DEF),
  parameter logic [ADDR_LEN-1:0] CYCLE_ADDR  = ADDR_LEN'(CYCLE_ADDR_DEF),
  parameter logic [ADDR_LEN-1:0] LED_ADDR    = ADDR_LEN'(LED_ADDR_DEF)
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                loading,
  input  logic [ADDR_LEN-1:0] core_addr,
  input  logic [DATA_LEN-1:0] core_wdata,
  input  logic                core_we,
  output logic                mmio_hit,
  output logic                mmio_rsel,
  output logic [DATA_LEN-1:0] mmio_rdata,
  output logic [7:0]          utx_data,
  output logic                utx_valid,
  input  logic                utx_ready,
  output logic [7:0]          led,
  output logic                finished
);

  localparam int AW = $clog2(FIFO_DEPTH);

  reg_sel_e            sel;
  logic                we_ok, utx_wr, fifo_push, fifo_pop, ovf_set, ovf_clr;
  logic                fifo_full, fifo_empty;
  logic [AW:0]         fifo_count;
  logic [7:0]          led_q, led_d;
  logic                finished_q, finished_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic                rsel_q;
  logic                unused_wdata;

  assign unused_wdata = &{1'b0, core_wdata[DATA_LEN-1:8]};

  always_comb begin
    sel = SEL_NONE;
    if      (core_addr == UTX_ADDR)    sel = SEL_UTX;
    else if (core_addr == STATUS_ADDR) sel = SEL_STATUS;
    else if (core_addr == FINISH_ADDR) sel = SEL_FINISH;
    else if (core_addr == CYCLE_ADDR)  sel = SEL_CYCLE;
    else if (core_addr == LED_ADDR)    sel = SEL_LED;
  end

  assign mmio_hit  = (sel != SEL_NONE);
  assign we_ok     = core_we && !loading;
  assign utx_wr    = we_ok && (sel == SEL_UTX) && !finished_q;
  assign fifo_push = utx_wr && !fifo_full;
  assign ovf_set   = utx_wr && fifo_full;
  assign ovf_clr   = we_ok && (sel == SEL_STATUS) && core_wdata[STAT_OVF];
  assign fifo_pop  = utx_valid && utx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_x (reset_x),
    .push_i  (fifo_push),
    .wdata_i (core_wdata[7:0]),
    .pop_i   (fifo_pop),
    .head_o  (utx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    led_d      = led_q;
    finished_d = finished_q;
    ovf_d      = ovf_q;
    cycle_d    = cycle_q;
    rdata_d    = '0;
    if (we_ok) begin
      case (sel)
        SEL_UTX:    if (fifo_push) led_d[6:0] = core_wdata[6:0];
        SEL_FINISH: begin
          led_d[7]   = 1'b1;
          finished_d = 1'b1;
        end
        SEL_LED:    led_d = core_wdata[7:0];
        default:    ;
      endcase
    end
    // Set wins over a concurrent clear.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (loading)          cycle_d = '0;
    else if (!finished_q) cycle_d = cycle_q + 32'd1;
    case (sel)
      SEL_STATUS: rdata_d = DATA_LEN'(pack_status(fifo_empty, fifo_full, finished_q,
                                                   ovf_q, 8'(fifo_count)));
      SEL_CYCLE:  rdata_d = DATA_LEN'(cycle_q);
      SEL_LED:    rdata_d = DATA_LEN'(led_q);
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      led_q      <= '0;
      finished_q <= 1'b0;
      ovf_q      <= 1'b0;
      cycle_q    <= '0;
      rdata_q    <= '0;
      rsel_q     <= 1'b0;
    end else begin
      led_q      <= led_d;
      finished_q <= finished_d;
      ovf_q      <= ovf_d;
      cycle_q    <= cycle_d;
      rdata_q    <= rdata_d;
      rsel_q     <= mmio_hit;
    end
  end

  assign utx_valid  = !fifo_empty;
  assign led        = led_q;
  assign finished   = finished_q;
  assign mmio_rdata = rdata_q;
  assign mmio_rsel  = rsel_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: stimulus queues expected read data and UART
// bytes; a negedge monitor pops and compares as the hub presents them.
module tb_mmio_hub;

  localparam logic [31:0] A_UTX  = 32'h0000_0000;
  localparam logic [31:0] A_STAT = 32'h0000_0004;
  localparam logic [31:0] A_FIN  = 32'h0000_0008;
  localparam logic [31:0] A_CYC  = 32'h0000_000C;
  localparam logic [31:0] A_LED  = 32'h0000_0010;
  localparam logic [31:0] A_MISS = 32'h0000_0014;
  localparam logic [31:0] A_IDLE = 32'h0000_0100;

  logic        clk, reset_x, loading, core_we, utx_ready;
  logic [31:0] core_addr, core_wdata;
  logic        mmio_hit, mmio_rsel, utx_valid, finished;
  logic [31:0] mmio_rdata;
  logic [7:0]  utx_data, led;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       nm;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [7:0]  tx_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cyc    = 0;
  logic [31:0] fin_val;

  mmio_hub dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .loading    (loading),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .mmio_hit   (mmio_hit),
    .mmio_rsel  (mmio_rsel),
    .mmio_rdata (mmio_rdata),
    .utx_data   (utx_data),
    .utx_valid  (utx_valid),
    .utx_ready  (utx_ready),
    .led        (led),
    .finished   (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  function automatic bit is_hub(input logic [31:0] a);
    return a inside {A_UTX, A_STAT, A_FIN, A_CYC, A_LED};
  endfunction

  // n_cyc tracks the expected cycle counter: cleared on a loading edge,
  // otherwise one per edge (only used while the hub is not finished).
  task automatic cyc();
    @(posedge clk);
    if (loading) n_cyc = 0;
    else         n_cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    rd_exp_t e;
    core_addr  = a;
    core_wdata = d;
    core_we    = 1'b1;
    if (is_hub(a)) begin
      e.chk = 1'b0; e.val = '0; e.nm = "wr_side_read";
      rd_q.push_back(e);
    end
    cyc();
    core_we    = 1'b0;
    core_wdata = '0;
    core_addr  = A_IDLE;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    rd_exp_t e;
    e.chk = 1'b1; e.val = exp; e.nm = nm;
    rd_q.push_back(e);
    core_addr = a;
    cyc();
    core_addr = A_IDLE;
  endtask

  task automatic push_tx(input logic [7:0] b);
    wr(A_UTX, {24'h0, b});
    tx_q.push_back(b);
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    logic [7:0] b;
    if (mmio_rsel) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected actual=rsel_1 required=rsel_0 rdata=0x%08h", mmio_rdata);
      end else begin
        e = rd_q.pop_front();
        if (e.chk) begin
          $display("read %s rdata=0x%08h", e.nm, mmio_rdata);
          chk(e.nm, mmio_rdata, e.val);
        end
      end
    end
    if (reset_x && utx_valid && utx_ready) begin
      if (tx_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected actual=0x%02h required=no_byte", utx_data);
      end else begin
        b = tx_q.pop_front();
        $display("uart byte 0x%02h", utx_data);
        chk("tx_byte", {24'h0, utx_data}, {24'h0, b});
      end
    end
  end

  initial begin
    reset_x = 1'b0; loading = 1'b0; core_we = 1'b0; utx_ready = 1'b0;
    core_addr = A_IDLE; core_wdata = '0;
    idle(2);
    chk("rst_rsel", {31'h0, mmio_rsel}, 32'h0);
    chk("rst_rdata", mmio_rdata, 32'h0);
    chk("rst_valid", {31'h0, utx_valid}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_finished", {31'h0, finished}, 32'h0);
    chk("hit_idle", {31'h0, mmio_hit}, 32'h0);
    reset_x = 1'b1;
    idle(2);

    // Loading suppresses all writes; counter held at 0.
    loading = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr(A_UTX, 32'hFF);
      wr(A_LED, 32'hFF);
    end
    wr(A_FIN, 32'h0);
    chk("load_led", {24'h0, led}, 32'h0);
    chk("load_valid", {31'h0, utx_valid}, 32'h0);
    chk("load_finished", {31'h0, finished}, 32'h0);
    rd(A_CYC, 32'h0, "load_cycle");
    rd(A_STAT, 32'h0000_0001, "load_status");
    loading = 1'b0;
    cyc();
    rd(A_CYC, 32'd1, "cycle_after_load");

    // Three queued bytes, then drain.
    push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
    chk("t1_led", {24'h0, led}, 32'h43);
    chk("t1_head", {24'h0, utx_data}, 32'h41);
    rd(A_STAT, 32'h0000_0300, "t1_status");
    utx_ready = 1'b1;
    idle(4);
    chk("t1_drained", {31'h0, utx_valid}, 32'h0);
    utx_ready = 1'b0;

    // Fill to 16, 17th dropped.
    for (int i = 0; i < 16; i++) push_tx(8'(8'h60 + i));
    wr(A_UTX, 32'h70);
    chk("t2_led", {24'h0, led}, 32'h6F);
    rd(A_STAT, 32'h0000_100A, "t2_status_ovf");
    wr(A_STAT, 32'h7);
    rd(A_STAT, 32'h0000_100A, "t2_status_noclr");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h0000_1002, "t2_status_clr");

    // Full with pop and push in the same cycle: push dropped.
    utx_ready = 1'b1;
    wr(A_UTX, 32'h99);
    utx_ready = 1'b0;
    chk("t5_led", {24'h0, led}, 32'h6F);
    rd(A_STAT, 32'h0000_0F08, "t5_status");
    wr(A_STAT, 32'h8);
    utx_ready = 1'b1;
    idle(16);
    utx_ready = 1'b0;
    chk("t5_drained", {31'h0, utx_valid}, 32'h0);
    rd(A_STAT, 32'h0000_0001, "t5_status_empty");

    // LED register, write-only reads, unmapped write, combinational hit.
    wr(A_LED, 32'hA5);
    chk("led_wr", {24'h0, led}, 32'hA5);
    rd(A_LED, 32'h0000_00A5, "led_rd");
    rd(A_UTX, 32'h0, "utx_rd_zero");
    rd(A_FIN, 32'h0, "fin_rd_zero");
    wr(A_MISS, 32'hFF);
    chk("miss_led", {24'h0, led}, 32'hA5);
    core_addr = A_LED;  #1;
    chk("hit_led", {31'h0, mmio_hit}, 32'h1);
    core_addr = A_MISS; #1;
    chk("hit_miss", {31'h0, mmio_hit}, 32'h0);
    core_addr = A_IDLE;

    // Finish with two bytes queued.
    push_tx(8'h31); push_tx(8'h32);
    chk("t3_led_pre", {24'h0, led}, 32'hB2);
    wr(A_FIN, 32'h0);
    fin_val = 32'(n_cyc);
    chk("t3_finished", {31'h0, finished}, 32'h1);
    wr(A_UTX, 32'h55);
    chk("t3_led", {24'h0, led}, 32'hB2);
    rd(A_STAT, 32'h0000_0204, "t3_status");
    rd(A_CYC, fin_val, "t3_cycle_a");
    idle(4);
    rd(A_CYC, fin_val, "t3_cycle_b");
    utx_ready = 1'b1;
    idle(3);
    chk("t3_drained", {31'h0, utx_valid}, 32'h0);
    utx_ready = 1'b0;

    // Reset mid-operation with five bytes queued and finished set.
    reset_x = 1'b0; cyc(); reset_x = 1'b1;
    for (int i = 1; i <= 5; i++) wr(A_UTX, 32'(i));
    wr(A_FIN, 32'h0);
    chk("t6_pre_valid", {31'h0, utx_valid}, 32'h1);
    chk("t6_pre_finished", {31'h0, finished}, 32'h1);
    reset_x = 1'b0; cyc();
    chk("t6_valid", {31'h0, utx_valid}, 32'h0);
    chk("t6_finished", {31'h0, finished}, 32'h0);
    chk("t6_led", {24'h0, led}, 32'h0);
    reset_x = 1'b1;
    rd(A_STAT, 32'h0000_0001, "t6_status");

    idle(2);
    for (int i = 0; i < 50 && (rd_q.size() != 0 || tx_q.size() != 0); i++) cyc();
    chk("rd_queue_left", 32'(rd_q.size()), 32'h0);
    chk("tx_queue_left", 32'(tx_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Memory-mapped I/O hub between the pipeline's data-memory port and the board peripherals. It replaces the ad-hoc address decode in the top level. It adds:
- a parametrised UART transmit FIFO with ready/valid backpressure, so back-to-back character writes are no longer lost while the UART is busy;
- a readable status register and a free-running cycle counter;
- a directly writable LED register.

It sits beside `dmem` in `top`. `top` steers core stores to either the hub or `dmem` using `mmio_hit`, and muxes load data using `mmio_rsel`.

## Interface
Parameters:
- `DATA_LEN`, 32, core data width.
- `ADDR_LEN`, 32, core address width.
- `FIFO_DEPTH`, 16, UART TX FIFO entries; must be a power of two, 2..128.
- `UTX_ADDR`, 32'h0, UART TX data register (write-only).
- `STATUS_ADDR`, 32'h4, status register (read; write-1-to-clear).
- `FINISH_ADDR`, 32'h8, finish register (write-only).
- `CYCLE_ADDR`, 32'hC, cycle counter (read-only).
- `LED_ADDR`, 32'h10, LED register (read/write).

Ports:
- `clk`  in  1  sole clock.
- `reset_x`  in  1  synchronous, active-low reset.
- `loading`  in  1  program loader active; high suppresses all effects.
- `core_addr`  in  ADDR_LEN  core data address.
- `core_wdata`  in  DATA_LEN  core store data.
- `core_we`  in  1  core store strobe.
- `mmio_hit`  out  1  combinational; `core_addr` matches any hub address.
- `mmio_rsel`  out  1  registered `mmio_hit`; aligned with `mmio_rdata`.
- `mmio_rdata`  out  DATA_LEN  registered read data.
- `utx_data`  out  8  FIFO head byte.
- `utx_valid`  out  1  FIFO non-empty.
- `utx_ready`  in  1  UART accepts byte this cycle.
- `led`  out  8  board LEDs.
- `finished`  out  1  sticky finish flag.

## Operation
- Address decode is an exact full-width compare against each `*_ADDR`. Writes that match no hub address have no effect in the hub.
- **UTX write** (hub not finished, not `loading`):
  - FIFO not full: push `core_wdata[7:0]`, and set `led[6:0]` <= `core_wdata[6:0]`.
  - FIFO full: drop the byte and set the sticky `overflow` flag; `led` is unchanged.
- **UTX write after finish** is ignored; the FIFO keeps draining.
- **FINISH write**: `finished` <= 1, `led[7]` <= 1.
- **LED write**: `led` <= `core_wdata[7:0]` (all eight bits).
- **STATUS write**: `core_wdata[3]` = 1 clears `overflow`. If an overflow set and a clear happen in the same cycle, set wins.
- **STATUS read layout**: bit0 empty, bit1 full, bit2 `finished`, bit3 `overflow`, bits[15:8] occupancy count (zero-extended), all other bits 0.
- **CYCLE read**: 32-bit counter.
  - Held at 0 while `loading`.
  - Increments every cycle otherwise.
  - Freezes once `finished` is set.
  - Wraps modulo 2^32.
- **LED read**: {24'b0, `led`}. Reads of write-only addresses return 0.
- **Drain side**:
  - `utx_valid` = !empty; `utx_data` = head entry.
  - A pop happens when `utx_valid && utx_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - A push to a full FIFO is dropped even if a pop occurs in the same cycle; the full check uses pre-pop state.
- **`loading` high**: all writes are ignored, but the FIFO still drains.

## Timing
- Reset (`reset_x` = 0 at a `clk` edge) clears the following; all outputs read 0 on the next cycle:
  - FIFO pointers, count, `overflow`, `finished`, `led`, cycle counter, `mmio_rdata`, `mmio_rsel`.
  - Therefore `utx_valid` = 0.
- Reset asserted mid-operation discards FIFO contents. A byte presented with `utx_valid` in the reset cycle is not considered popped by the hub.
- **Write effects** are visible from the cycle after `core_we`. A pushed byte appears on `utx_valid`/`utx_data` one cycle after the write.
- **Read latency** is one cycle: `mmio_rdata`/`mmio_rsel` reflect the `core_addr` of the previous cycle, matching `dmem` timing. No read strobe is used; a read is evaluated every cycle.
- **STATUS read concurrent with a push/pop** returns the pre-update state.
- **Throughput**: one push and one pop per cycle.

## Structure
- The `*_ADDR` defaults and the STATUS bit positions belong as shared constants in `constants.vh` so the firmware headers and `top` use one source.
- One sub-module, `sync_fifo`, provides:
  - parameters: width, depth;
  - ports: push/pop, full/empty/count, head data;
  - storage: register array, read head combinational from the array.
- The hub itself is decode, registers, counter and read mux.

## Test plan
- After reset, write 0x41, 0x42, 0x43 to `UTX_ADDR` on consecutive cycles with `utx_ready` = 0 -> count = 3, `led` = 0x43. Then raise `utx_ready` -> `utx_data` is 0x41, 0x42, 0x43 on successive cycles, then `utx_valid` = 0.
- With `utx_ready` = 0, write 17 bytes (depth 16) -> the 17th byte is dropped and STATUS reads 0x0000_100A (count 16, full, overflow). Write 0x8 to STATUS -> it reads 0x0000_1002.
- Write FINISH while 2 bytes are queued -> `finished` = 1, `led[7]` = 1, and a further UTX write of 0x55 is not queued. Both queued bytes still drain. CYCLE reads the same value on two reads 5 cycles apart.
- Hold `loading` = 1 for 10 cycles with UTX/LED writes -> `led` = 0, FIFO empty, CYCLE = 0. Deassert -> CYCLE reads 1 at the first read issued two cycles after deassertion.
- FIFO full, `utx_ready` = 1, UTX write in the same cycle -> byte dropped, `overflow` set, count = 15.
- Assert `reset_x` = 0 with 5 bytes queued and `finished` = 1 -> the next cycle shows `utx_valid` = 0, `finished` = 0, `led` = 0, and STATUS reads 0x0000_0001.
